// File: rtl/ser_arb4_pkg.sv
// Shared constants and types for the four-channel serial arbiter.
// State encodings are fixed so external checkers can decode the FSM directly.
package ser_arb4_pkg;

    localparam int NCH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    function automatic logic [NCH-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/ser_arb4_rr_pick4.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping mod 4.
module rr_pick4
    import ser_arb4_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic [1:0] idx;

    always_comb begin
        gnt_idx = ptr;
        any     = 1'b0;
        idx     = ptr;
        for (int k = 0; k < NCH; k++) begin
            idx = ptr + 2'(k);
            if (!any && req[idx]) begin
                gnt_idx = idx;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ser_arb4.sv
// Four-channel round-robin arbiter feeding one MSB-first serial shifter.
// Handshake: req[i] is a level; a one-cycle ack[i] marks capture of data word i.
module ser_arb4
    import ser_arb4_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int GAP_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [3:0]           req,
    input  logic [NCH*WIDTH-1:0] data,
    output logic [3:0]           ack,
    output logic [1:0]           ch,
    output logic                 busy,
    output logic                 so
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [4:0]       bit_q, bit_d;
    logic [3:0]       gap_q, gap_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       ch_d;
    logic [3:0]       ack_d;
    logic             busy_d;

    logic [1:0]       gnt_idx;
    logic             gnt_any;

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            ptr_q   <= '0;
            ch      <= '0;
            ack     <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            ch      <= ch_d;
            ack     <= ack_d;
            busy    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
        ch_d    = ch;
        ack_d   = '0;
        busy_d  = busy;
        unique case (state_q)
            S_IDLE: begin
                if (en && gnt_any) begin
                    shreg_d = data[int'(gnt_idx)*WIDTH +: WIDTH];
                    ch_d    = gnt_idx;
                    ack_d   = onehot4(gnt_idx);
                    busy_d  = 1'b1;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_d = shreg_q << 1;
                bit_d   = bit_q + 5'd1;
                // Pointer advances only once the frame is done, so a held req waits its turn.
                if (bit_q == 5'(WIDTH-1)) begin
                    busy_d = 1'b0;
                    ptr_d  = ch + 2'd1;
                    if (GAP_CYC > 0) begin
                        gap_d   = 4'(GAP_CYC-1);
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign so = busy & shreg_q[WIDTH-1];

endmodule
